// File: rtl/traffic_phase_scheduler.sv
// Phase sequencer for a main/side intersection with a pedestrian crossing over the main road.
// Timing is counted in external enable ticks. Lamps and the walk lamp are registered one cycle after the state.
module traffic_phase_scheduler #(
    parameter int T_GREEN_MIN = 50,
    parameter int T_GREEN_MAX = 150,
    parameter int T_SIDE_G    = 60,
    parameter int T_YELLOW    = 30,
    parameter int T_ALLRED    = 10,
    parameter int T_WALK      = 40,
    parameter int T_BLINK     = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic       req_side,
    input  logic       req_ped,
    input  logic       night_mode,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic [1:0] pending
);

    typedef enum logic [2:0] {
        MAIN_G  = 3'd0,
        MAIN_Y  = 3'd1,
        ALLRED1 = 3'd2,
        SIDE_G  = 3'd3,
        SIDE_Y  = 3'd4,
        ALLRED2 = 3'd5,
        FLASH   = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] GMIN_L  = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_L  = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] SIDEG_L = CNT_W'(T_SIDE_G - 1);
    localparam logic [CNT_W-1:0] YEL_L   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_L    = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] BLINK_L = CNT_W'(T_BLINK - 1);
    localparam logic [CNT_W-1:0] WALK_L  = CNT_W'(T_WALK);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             blink_q, blink_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             walk_flag_q, walk_flag_d;
    logic [2:0]       main_light_q, main_light_d;
    logic [2:0]       side_light_q, side_light_d;
    logic             ped_walk_q, ped_walk_d;
    logic             adv;
    logic             restart;
    logic             side_start;
    logic             any_pend;

    assign adv        = tick && enable;
    assign any_pend   = side_pend_q || ped_pend_q;
    assign side_start = adv && (state_q == ALLRED1) && (elapsed_q == AR_L) && !night_mode;

    // Next-state, elapsed counter and blink; FLASH restarts the counter each half-period without leaving the state.
    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        blink_d   = blink_q;
        restart   = 1'b0;
        if (adv) begin
            case (state_q)
                MAIN_G: begin
                    if (night_mode ||
                        ((elapsed_q >= GMIN_L) && any_pend) ||
                        ((elapsed_q >= GMAX_L) && any_pend))
                        state_d = MAIN_Y;
                end
                MAIN_Y:  if (elapsed_q == YEL_L)   state_d = ALLRED1;
                ALLRED1: if (elapsed_q == AR_L)    state_d = night_mode ? FLASH : SIDE_G;
                SIDE_G:  if (elapsed_q == SIDEG_L) state_d = SIDE_Y;
                SIDE_Y:  if (elapsed_q == YEL_L)   state_d = ALLRED2;
                ALLRED2: if (elapsed_q == AR_L)    state_d = MAIN_G;
                FLASH: begin
                    if (!night_mode) begin
                        state_d = ALLRED2;
                        blink_d = 1'b0;
                    end else if (elapsed_q == BLINK_L) begin
                        blink_d = ~blink_q;
                        restart = 1'b1;
                    end
                end
                default: state_d = ALLRED2;
            endcase
            if ((state_d != state_q) || restart)
                elapsed_d = '0;
            else if (elapsed_q != '1)
                elapsed_d = elapsed_q + 1'b1;
        end
    end

    // Request latches keep capturing while frozen; the side-green start clears them and wins over a new request.
    always_comb begin
        side_pend_d = side_pend_q;
        ped_pend_d  = ped_pend_q;
        walk_flag_d = walk_flag_q;
        if (side_start) begin
            side_pend_d = 1'b0;
            ped_pend_d  = 1'b0;
            walk_flag_d = ped_pend_q || req_ped;
        end else if (state_q != SIDE_G) begin
            if (req_side) side_pend_d = 1'b1;
            if (req_ped)  ped_pend_d  = 1'b1;
        end
    end

    always_comb begin
        main_light_d = LAMP_R;
        side_light_d = LAMP_R;
        case (state_q)
            MAIN_G: main_light_d = LAMP_G;
            MAIN_Y: main_light_d = LAMP_Y;
            SIDE_G: side_light_d = LAMP_G;
            SIDE_Y: side_light_d = LAMP_Y;
            FLASH: begin
                main_light_d = {1'b0, blink_q, 1'b0};
                side_light_d = {1'b0, blink_q, 1'b0};
            end
            default: ;
        endcase
        ped_walk_d = walk_flag_q && (state_q == SIDE_G) && (elapsed_q < WALK_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ALLRED2;
            elapsed_q    <= '0;
            blink_q      <= 1'b0;
            side_pend_q  <= 1'b0;
            ped_pend_q   <= 1'b0;
            walk_flag_q  <= 1'b0;
            main_light_q <= LAMP_R;
            side_light_q <= LAMP_R;
            ped_walk_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            elapsed_q    <= elapsed_d;
            blink_q      <= blink_d;
            side_pend_q  <= side_pend_d;
            ped_pend_q   <= ped_pend_d;
            walk_flag_q  <= walk_flag_d;
            main_light_q <= main_light_d;
            side_light_q <= side_light_d;
            ped_walk_q   <= ped_walk_d;
        end
    end

    assign main_light = main_light_q;
    assign side_light = side_light_q;
    assign ped_walk   = ped_walk_q;
    assign phase      = state_q;
    assign pending    = {ped_pend_q, side_pend_q};

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: expected output snapshots are queued per step
// and compared once the registered outputs have settled after the step's ticks.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       enable;
    logic       reqSide;
    logic       reqPed;
    logic       nightMode;
    logic [2:0] mainLight;
    logic [2:0] sideLight;
    logic       pedWalk;
    logic [2:0] phase;
    logic [1:0] pending;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef struct {
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t sbQ[$];
    int   errors = 0;
    int   checks = 0;

    traffic_phase_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .enable     (enable),
        .req_side   (reqSide),
        .req_ped    (reqPed),
        .night_mode (nightMode),
        .main_light (mainLight),
        .side_light (sideLight),
        .ped_walk   (pedWalk),
        .phase      (phase),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Snapshot layout: {phase, main, side, walk, pending}.
    function automatic logic [11:0] mk(input logic [2:0] ph, input logic [2:0] ml,
                                       input logic [2:0] sl, input logic pw,
                                       input logic [1:0] pd);
        return {ph, ml, sl, pw, pd};
    endfunction

    // One tick takes two clocks so both the state and the registered lamps have settled afterwards.
    task automatic doTick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [11:0] obs;
        checks++;
        assert (sbQ.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard: observed=empty required=entry");
        end
        if (sbQ.size() != 0) begin
            e   = sbQ.pop_front();
            obs = {phase, mainLight, sideLight, pedWalk, pending};
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed ph=%0d main=%b side=%b walk=%b pend=%b required ph=%0d main=%b side=%b walk=%b pend=%b",
                       e.tag, obs[11:9], obs[8:6], obs[5:3], obs[2], obs[1:0],
                       e.val[11:9], e.val[8:6], e.val[5:3], e.val[2], e.val[1:0]);
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input int nTicks, input logic [11:0] expVal);
        exp_t e;
        e.tag = tag;
        e.val = expVal;
        sbQ.push_back(e);
        for (int i = 0; i < nTicks; i++) doTick();
        checkOutput();
    endtask

    task automatic pulseReq(input logic s, input logic p);
        @(negedge clk) begin
            reqSide = s;
            reqPed  = p;
        end
        @(negedge clk) begin
            reqSide = 1'b0;
            reqPed  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus("reset", 0, mk(5, R, R, 0, 2'b00));
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        tick      = 1'b0;
        enable    = 1'b1;
        reqSide   = 1'b0;
        reqPed    = 1'b0;
        nightMode = 1'b0;

        // Power-up into ALLRED2, then rest in MAIN_G forever without requests.
        resetDut();
        applyStimulus("t1_tick1",   1,   mk(5, R, R, 0, 2'b00));
        applyStimulus("t1_tick9",   8,   mk(5, R, R, 0, 2'b00));
        applyStimulus("t1_tick10",  1,   mk(0, G, R, 0, 2'b00));
        applyStimulus("t1_idle200", 200, mk(0, G, R, 0, 2'b00));
        applyStimulus("t1_idle500", 300, mk(0, G, R, 0, 2'b00));

        // Early side request waits for minimum green.
        resetDut();
        applyStimulus("t2_mainG", 10, mk(0, G, R, 0, 2'b00));
        applyStimulus("t2_e5",    5,  mk(0, G, R, 0, 2'b00));
        pulseReq(1'b1, 1'b0);
        applyStimulus("t2_sidePend", 0,  mk(0, G, R, 0, 2'b01));
        applyStimulus("t2_e49",      44, mk(0, G, R, 0, 2'b01));
        applyStimulus("t2_mainY",    1,  mk(1, Y, R, 0, 2'b01));
        applyStimulus("t2_y29",      29, mk(1, Y, R, 0, 2'b01));
        applyStimulus("t2_allred1",  1,  mk(2, R, R, 0, 2'b01));
        applyStimulus("t2_ar9",      9,  mk(2, R, R, 0, 2'b01));
        applyStimulus("t2_sideG",    1,  mk(3, R, G, 0, 2'b00));
        applyStimulus("t2_sideG30",  30, mk(3, R, G, 0, 2'b00));
        applyStimulus("t2_sideY",    30, mk(4, R, Y, 0, 2'b00));
        applyStimulus("t2_allred2",  30, mk(5, R, R, 0, 2'b00));
        applyStimulus("t2_back",     10, mk(0, G, R, 0, 2'b00));

        // Late pedestrian request yields at once; walk lasts T_WALK ticks.
        applyStimulus("t3_e70", 70, mk(0, G, R, 0, 2'b00));
        pulseReq(1'b0, 1'b1);
        applyStimulus("t3_pedPend",  0,  mk(0, G, R, 0, 2'b10));
        applyStimulus("t3_mainY",    1,  mk(1, Y, R, 0, 2'b10));
        applyStimulus("t3_allred1",  30, mk(2, R, R, 0, 2'b10));
        applyStimulus("t3_sideG",    10, mk(3, R, G, 1, 2'b00));
        applyStimulus("t3_walk39",   39, mk(3, R, G, 1, 2'b00));
        applyStimulus("t3_walkEnd",  1,  mk(3, R, G, 0, 2'b00));
        applyStimulus("t3_sideG59",  19, mk(3, R, G, 0, 2'b00));
        applyStimulus("t3_sideY",    1,  mk(4, R, Y, 0, 2'b00));
        applyStimulus("t3_allred2",  30, mk(5, R, R, 0, 2'b00));
        applyStimulus("t3_mainG",    10, mk(0, G, R, 0, 2'b00));

        // Night mode: immediate yield, flashing yellow, clean exit through ALLRED2.
        nightMode = 1'b1;
        applyStimulus("t4_mainY",    1,  mk(1, Y, R, 0, 2'b00));
        applyStimulus("t4_allred1",  30, mk(2, R, R, 0, 2'b00));
        applyStimulus("t4_flash",    10, mk(6, OFF, OFF, 0, 2'b00));
        applyStimulus("t4_flash4",   4,  mk(6, OFF, OFF, 0, 2'b00));
        applyStimulus("t4_blinkOn",  1,  mk(6, Y, Y, 0, 2'b00));
        applyStimulus("t4_on4",      4,  mk(6, Y, Y, 0, 2'b00));
        applyStimulus("t4_blinkOff", 1,  mk(6, OFF, OFF, 0, 2'b00));
        nightMode = 1'b0;
        applyStimulus("t4_exit",     1,  mk(5, R, R, 0, 2'b00));
        applyStimulus("t4_ar9",      9,  mk(5, R, R, 0, 2'b00));
        applyStimulus("t4_mainG",    1,  mk(0, G, R, 0, 2'b00));

        // Freeze in SIDE_Y at elapsed 12 while requests still latch.
        pulseReq(1'b1, 1'b0);
        applyStimulus("t5_sidePend", 0,  mk(0, G, R, 0, 2'b01));
        applyStimulus("t5_mainY",    50, mk(1, Y, R, 0, 2'b01));
        applyStimulus("t5_sideG",    40, mk(3, R, G, 0, 2'b00));
        applyStimulus("t5_sideY",    60, mk(4, R, Y, 0, 2'b00));
        applyStimulus("t5_y12",      12, mk(4, R, Y, 0, 2'b00));
        enable  = 1'b0;
        reqSide = 1'b1;
        applyStimulus("t5_frozen", 500, mk(4, R, Y, 0, 2'b01));
        enable  = 1'b1;
        reqSide = 1'b0;
        applyStimulus("t5_y29",     17, mk(4, R, Y, 0, 2'b01));
        applyStimulus("t5_allred2", 1,  mk(5, R, R, 0, 2'b01));
        applyStimulus("t5_mainG",   10, mk(0, G, R, 0, 2'b01));

        // Asynchronous reset in the middle of an active walk.
        pulseReq(1'b0, 1'b1);
        applyStimulus("t6_pend",  0,  mk(0, G, R, 0, 2'b11));
        applyStimulus("t6_mainY", 50, mk(1, Y, R, 0, 2'b11));
        applyStimulus("t6_sideG", 40, mk(3, R, G, 1, 2'b00));
        applyStimulus("t6_g20",   20, mk(3, R, G, 1, 2'b00));
        #2 rst = 1'b1;
        #1 applyStimulus("t6_rstAsync", 0, mk(5, R, R, 0, 2'b00));
        @(negedge clk) rst = 1'b0;
        applyStimulus("t6_release", 1, mk(5, R, R, 0, 2'b00));
        applyStimulus("t6_mainG",   9, mk(0, G, R, 0, 2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Phase sequencer for a two-road intersection: main road, side road, and a pedestrian crossing over the main road.
- Main green is the rest phase. It yields to the side road on side-road vehicle or pedestrian demand, with min/max green timing.
- All timing is counted in ticks from an external 10 Hz enable pulse, produced by the existing clock divider.
- Sits between the divider and the pad outputs. Drives lamp and walk signals plus a phase code for debug.

Parameters:
T_GREEN_MIN, 50, minimum main green, in ticks.
T_GREEN_MAX, 150, main green at which a pending request forces the change, in ticks.
T_SIDE_G, 60, side green duration, in ticks.
T_YELLOW, 30, yellow duration (both roads), in ticks.
T_ALLRED, 10, all-red clearance duration, in ticks.
T_WALK, 40, walk duration at the start of side green, in ticks (≤ T_SIDE_G).
T_BLINK, 5, half-period of night-mode flashing, in ticks.
CNT_W, 8, elapsed-counter width (must hold T_GREEN_MAX).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  timing enable; every clk cycle it is high counts as one tick
enable  in  1  high = run; low = freeze counters and state, hold outputs
req_side  in  1  side-road vehicle sensor, level, already synchronised
req_ped  in  1  pedestrian button, level, already synchronised
night_mode  in  1  request flashing-yellow operation
main_light  out  3  {red,yellow,green} for the main road
side_light  out  3  {red,yellow,green} for the side road
ped_walk  out  1  walk lamp for pedestrians crossing the main road
phase  out  3  current state code
pending  out  2  {ped_pend, side_pend}

Behaviour:
- States and codes: MAIN_G=0, MAIN_Y=1, ALLRED1=2, SIDE_G=3, SIDE_Y=4, ALLRED2=5, FLASH=6. Code 7 is illegal and recovers to ALLRED2.
- elapsed counter (CNT_W bits):
  - Cleared on every state transition.
  - Otherwise incremented when tick && enable, saturating at all-ones.
- Transitions are evaluated only on cycles with tick && enable. "elapsed==N-1 on tick" means a state lasts exactly N ticks.
- Reset values: state=ALLRED2, elapsed=0, side_pend=0, ped_pend=0, walk_flag=0, blink=0, main_light=100, side_light=100, ped_walk=0, phase=5.
- MAIN_G transitions:
  - night_mode=1 → MAIN_Y immediately on tick, ignoring T_GREEN_MIN.
  - Else, if elapsed ≥ T_GREEN_MIN-1 and (side_pend|ped_pend) → MAIN_Y.
  - elapsed ≥ T_GREEN_MAX-1 with a request pending also → MAIN_Y; this condition is implied by the previous one and kept as an explicit cap.
  - With no request, stay in MAIN_G indefinitely.
- MAIN_Y → ALLRED1 at elapsed==T_YELLOW-1.
- ALLRED1 at elapsed==T_ALLRED-1 → FLASH if night_mode, else SIDE_G.
- SIDE_G → SIDE_Y at elapsed==T_SIDE_G-1. night_mode does not shorten it.
- SIDE_Y → ALLRED2 at elapsed==T_YELLOW-1.
- ALLRED2 → MAIN_G at elapsed==T_ALLRED-1.
- FLASH:
  - blink toggles on each tick where elapsed reaches T_BLINK-1; elapsed is then cleared without a state change.
  - night_mode=0 on tick → ALLRED2, with blink cleared.
- Lamp decode:
  - MAIN_G: main=001, side=100.
  - MAIN_Y: main=010, side=100.
  - SIDE_G: main=100, side=001.
  - SIDE_Y: main=100, side=010.
  - ALLRED1/2: both 100.
  - FLASH: both {0,blink,0}.
  - Lamp outputs are registered (one cycle after the state register). Exactly one lamp per road is lit, except in FLASH.
- Pending latches:
  - side_pend set on any cycle with req_side=1 while state≠SIDE_G; ped_pend likewise from req_ped.
  - Both are cleared on the cycle of the ALLRED1→SIDE_G transition. Clear wins over a same-cycle set.
  - Requests during SIDE_G are not latched.
- walk_flag is loaded on the ALLRED1→SIDE_G transition with (ped_pend|req_ped).
- ped_walk = walk_flag && state==SIDE_G && elapsed < T_WALK, registered.
- enable=0: no state, elapsed or blink change. Pending latches still capture requests. Outputs hold.
- rst asserted mid-phase: all registers go to reset values asynchronously and lamps go all-red immediately. Release resumes from ALLRED2.

Test Plan:
- Reset then 10 ticks, no requests → phase 5 for ticks 1-10, phase 0 with main=001 after tick 10; stays 0 for 500 ticks.
- req_side pulse for 1 cycle at main-green elapsed=5 → side_pend=1; MAIN_Y after tick 50, ALLRED1 after 30 more, SIDE_G after 10 more with side=001; ped_walk=0 throughout; side_pend=0 in SIDE_G.
- req_ped at elapsed=70 of MAIN_G → immediate MAIN_Y on next tick; in SIDE_G ped_walk=1 for exactly 40 ticks, then 0 for 20 ticks; after SIDE_Y and ALLRED2 back to MAIN_G.
- night_mode=1 during MAIN_G → MAIN_Y(30), ALLRED1(10), FLASH with both lights toggling 010/000 every 5 ticks; night_mode=0 → ALLRED2 for 10 ticks then MAIN_G.
- enable=0 for 1000 cycles with tick pulsing during SIDE_Y at elapsed=12 → phase stays 4, elapsed stays 12; req_side held during this window sets side_pend; enable=1 resumes with 18 ticks remaining.
- rst pulsed at SIDE_G elapsed=20 with walk active → same cycle: side=100, main=100, ped_walk=0, pending=00; phase=5 after release.
